// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on / system reset generator.
// Holds N_CH active-low reset domains in reset, waits for the POR delay and a
// filtered PLL lock, then releases the domains in ascending order with an
// optional per-domain ready handshake. A debounced button press or a loss of
// PLL lock re-asserts every domain and records the cause.
module reset_sequencer #(
   parameter int              N_CH            = 3,
   parameter int              POR_CYCLES      = 100,
   parameter int              LOCK_FILTER     = 8,
   parameter int              STAGE_GAP       = 16,
   parameter int              DEBOUNCE_CYCLES = 1000,
   parameter logic [N_CH-1:0] USE_ACK         = {N_CH{1'b0}},
   parameter int              ACK_TIMEOUT     = 65535,
   parameter int              CNT_W           = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pll_locked,
   input  logic            btn_rst,
   input  logic [N_CH-1:0] ch_ack,
   output logic [N_CH-1:0] rst_n_out,
   output logic            all_released,
   output logic            timeout_err,
   output logic [1:0]      reset_cause
);

   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(STAGE_GAP);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [1:0] CAUSE_POR = 2'd0;
   localparam logic [1:0] CAUSE_BTN = 2'd1;
   localparam logic [1:0] CAUSE_PLL = 2'd2;

   typedef enum logic [2:0] {
      S_POR       = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_REL       = 3'd2,
      S_RUN       = 3'd3,
      S_HOLD      = 3'd4
   } state_t;

   // Saturating increment: counters never wrap back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

   // Synchroniser and debouncer state
   logic             lock_meta_r, lock_sync_r, lock_prev_r;
   logic             btn_meta_r, btn_sync_r, btn_db_r, btn_db_prev_r;
   logic [CNT_W-1:0] deb_cnt_r;
   logic             btn_rise_s, lock_fall_s;

   // Sequencer state
   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [CNT_W-1:0] lock_cnt_r, lock_cnt_nxt_s;
   logic [CNT_W-1:0] ack_cnt_r, ack_cnt_nxt_s;
   logic [IDX_W-1:0] idx_r, idx_nxt_s;
   logic [N_CH-1:0]  rst_n_r, rst_n_nxt_s;
   logic             all_rel_r, all_rel_nxt_s;
   logic             tmo_r, tmo_nxt_s;
   logic [1:0]       cause_r, cause_nxt_s;

   // Per-channel selection helpers
   logic             ack_need_s, ack_in_s, ack_ok_s, last_s;
   logic [N_CH-1:0]  rel_mask_s;

   // Two-flop synchronisers for the asynchronous lock and button inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
         lock_prev_r <= 1'b0;
         btn_meta_r  <= 1'b0;
         btn_sync_r  <= 1'b0;
      end else begin
         lock_meta_r <= pll_locked;
         lock_sync_r <= lock_meta_r;
         lock_prev_r <= lock_sync_r;
         btn_meta_r  <= btn_rst;
         btn_sync_r  <= btn_meta_r;
      end
   end

   // Debouncer: adopt the synced level after it has differed for the full window
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_db_r      <= 1'b0;
         btn_db_prev_r <= 1'b0;
         deb_cnt_r     <= CNT_ZERO;
      end else begin
         btn_db_prev_r <= btn_db_r;
         if (btn_sync_r != btn_db_r) begin
            if (deb_cnt_r == DEB_LAST) begin
               btn_db_r  <= btn_sync_r;
               deb_cnt_r <= CNT_ZERO;
            end else begin
               deb_cnt_r <= sat_inc(deb_cnt_r);
            end
         end else begin
            deb_cnt_r <= CNT_ZERO;
         end
      end
   end

   assign btn_rise_s  = btn_db_r & ~btn_db_prev_r;
   assign lock_fall_s = lock_prev_r & ~lock_sync_r;

   // Select the ack controls of the current channel and the mask of the next one
   always_comb begin
      ack_need_s = 1'b0;
      ack_in_s   = 1'b0;
      rel_mask_s = {N_CH{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         ack_need_s    = ack_need_s | (USE_ACK[k] & (k == int'(idx_r)));
         ack_in_s      = ack_in_s | (ch_ack[k] & (k == int'(idx_r)));
         rel_mask_s[k] = (k == int'(idx_r) + 1);
      end
      ack_ok_s = ~ack_need_s | ack_in_s;
      last_s   = (int'(idx_r) == N_CH - 2);
   end

   // Next-state and next-output logic of the release sequencer
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      lock_cnt_nxt_s = lock_cnt_r;
      ack_cnt_nxt_s  = ack_cnt_r;
      idx_nxt_s      = idx_r;
      rst_n_nxt_s    = rst_n_r;
      all_rel_nxt_s  = all_rel_r;
      tmo_nxt_s      = tmo_r;
      cause_nxt_s    = cause_r;
      case (state_r)
         S_POR: begin
            // Button events are ignored here; only the debouncer tracks the level.
            if (cnt_r == POR_LAST) begin
               state_nxt_s    = S_WAIT_LOCK;
               cnt_nxt_s      = CNT_ZERO;
               lock_cnt_nxt_s = CNT_ZERO;
            end else begin
               cnt_nxt_s = sat_inc(cnt_r);
            end
         end
         S_WAIT_LOCK: begin
            if (btn_rise_s) begin
               state_nxt_s   = S_HOLD;
               rst_n_nxt_s   = {N_CH{1'b0}};
               all_rel_nxt_s = 1'b0;
               cnt_nxt_s     = CNT_ZERO;
               cause_nxt_s   = CAUSE_BTN;
            end else if (!lock_sync_r) begin
               lock_cnt_nxt_s = CNT_ZERO;
            end else if (lock_cnt_r == LOCK_LAST) begin
               rst_n_nxt_s[0] = 1'b1;
               cnt_nxt_s      = CNT_ZERO;
               ack_cnt_nxt_s  = CNT_ZERO;
               idx_nxt_s      = {IDX_W{1'b0}};
               if (N_CH == 1) begin
                  all_rel_nxt_s = 1'b1;
                  state_nxt_s   = S_RUN;
               end else begin
                  state_nxt_s = S_REL;
               end
            end else begin
               lock_cnt_nxt_s = sat_inc(lock_cnt_r);
            end
         end
         S_REL: begin
            // cnt_r below GAP_LAST: gap running; equal: gap ends this edge;
            // above: gap over, waiting for the ack with ack_cnt_r as timer.
            if (btn_rise_s || lock_fall_s) begin
               state_nxt_s   = S_HOLD;
               rst_n_nxt_s   = {N_CH{1'b0}};
               all_rel_nxt_s = 1'b0;
               cnt_nxt_s     = CNT_ZERO;
               cause_nxt_s   = btn_rise_s ? CAUSE_BTN : CAUSE_PLL;
            end else if (cnt_r < GAP_LAST) begin
               cnt_nxt_s = sat_inc(cnt_r);
            end else if (ack_ok_s || ((cnt_r != GAP_LAST) && (ack_cnt_r == ACK_LAST))) begin
               rst_n_nxt_s   = rst_n_r | rel_mask_s;
               tmo_nxt_s     = tmo_r | ~ack_ok_s;
               cnt_nxt_s     = CNT_ZERO;
               ack_cnt_nxt_s = CNT_ZERO;
               if (last_s) begin
                  all_rel_nxt_s = 1'b1;
                  state_nxt_s   = S_RUN;
               end else begin
                  idx_nxt_s = idx_r + IDX_W'(1);
               end
            end else begin
               cnt_nxt_s = GAP_END;
               if (cnt_r != GAP_LAST) begin
                  ack_cnt_nxt_s = sat_inc(ack_cnt_r);
               end else begin
                  ack_cnt_nxt_s = CNT_ZERO;
               end
            end
         end
         S_RUN: begin
            if (btn_rise_s || lock_fall_s) begin
               state_nxt_s   = S_HOLD;
               rst_n_nxt_s   = {N_CH{1'b0}};
               all_rel_nxt_s = 1'b0;
               cnt_nxt_s     = CNT_ZERO;
               cause_nxt_s   = btn_rise_s ? CAUSE_BTN : CAUSE_PLL;
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         S_HOLD: begin
            // The hold count only advances once the button has been let go.
            if (btn_rise_s) begin
               cnt_nxt_s   = CNT_ZERO;
               cause_nxt_s = CAUSE_BTN;
            end else if (btn_db_r) begin
               cnt_nxt_s = cnt_r;
            end else if (cnt_r == POR_LAST) begin
               state_nxt_s    = S_WAIT_LOCK;
               cnt_nxt_s      = CNT_ZERO;
               lock_cnt_nxt_s = CNT_ZERO;
            end else begin
               cnt_nxt_s = sat_inc(cnt_r);
            end
         end
         default: begin
            state_nxt_s   = S_POR;
            cnt_nxt_s     = CNT_ZERO;
            rst_n_nxt_s   = {N_CH{1'b0}};
            all_rel_nxt_s = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_POR;
         cnt_r      <= CNT_ZERO;
         lock_cnt_r <= CNT_ZERO;
         ack_cnt_r  <= CNT_ZERO;
         idx_r      <= {IDX_W{1'b0}};
         rst_n_r    <= {N_CH{1'b0}};
         all_rel_r  <= 1'b0;
         tmo_r      <= 1'b0;
         cause_r    <= CAUSE_POR;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         lock_cnt_r <= lock_cnt_nxt_s;
         ack_cnt_r  <= ack_cnt_nxt_s;
         idx_r      <= idx_nxt_s;
         rst_n_r    <= rst_n_nxt_s;
         all_rel_r  <= all_rel_nxt_s;
         tmo_r      <= tmo_nxt_s;
         cause_r    <= cause_nxt_s;
      end
   end

   assign rst_n_out    = rst_n_r;
   assign all_released = all_rel_r;
   assign timeout_err  = tmo_r;
   assign reset_cause  = cause_r;

endmodule
